grf_wb_arbiter: RTL
===================

// Module: grf_wb_arbiter
// PURPOSE
//  Write-back initiator for the register file's single write port (WE/A3/WD + trace PC).
//  Merges two producers: the in-order pipeline W-stage (highest priority, no backpressure)
//  and the multi-cycle MDU/long-latency unit (valid/ready handshake, buffered in a FIFO).
//  Also reports queued-write hazards on two read addresses, for the stall/hazard unit.
// PARAMETERS
//  DEPTH        4   MDU result queue entries (power of 2, >=2)
//  STARVE_LIMIT 8   cycles a queue head may wait before the guard fires (guard build only)
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous reset, active-low
//  p_valid   in   1   pipeline write-back request (always accepted unless p_stall)
//  p_addr    in   5   pipeline destination register
//  p_data    in   32  pipeline write data
//  p_pc      in   32  pipeline instruction PC (trace)
//  m_valid   in   1   MDU result valid
//  m_ready   out  1   MDU result accepted this cycle when m_valid&&m_ready
//  m_addr    in   5   MDU destination register
//  m_data    in   32  MDU write data
//  m_pc      in   32  MDU instruction PC
//  we        out  1   register-file write enable (registered)
//  wa        out  5   register-file write address (registered)
//  wd        out  32  register-file write data (registered)
//  wpc       out  32  PC of the issued write (registered)
//  q_addr1   in   5   read address 1 to check
//  q_addr2   in   5   read address 2 to check
//  q_busy1   out  1   a queued entry targets q_addr1 (0 when q_addr1==0)
//  q_busy2   out  1   a queued entry targets q_addr2 (0 when q_addr2==0)
//  count     out  $clog2(DEPTH)+1  queue occupancy
//  p_stall   out  1   pipeline must hold its result this cycle (guard build; else 0)
// BEHAVIOUR
//  - Reset (async, rst_n low): we=0, wa=0, wd=0, wpc=0, count=0, head/tail=0,
//    all entries invalid, m_ready=0, p_stall=0, age counter=0. Takes effect immediately.
//  - m_ready = rst_n && (count<DEPTH); combinational. No push when full.
//  - Per cycle, issue choice (registered into we/wa/wd/wpc, 1-cycle latency):
//    1) p_valid && p_addr!=0 && !p_stall -> issue pipeline write;
//    2) else if count>0 -> pop FIFO head and issue it;
//    3) else we<=0 (wa/wd/wpc hold last value).
//  - MDU handshake with m_addr==0: accepted (m_ready honoured) but discarded, never queued.
//    Pipeline request with p_addr==0: dropped, never issued; the queue may pop that cycle.
//  - Push and pop in the same cycle: both occur; count unchanged. No bypass: a pushed
//    entry issues at earliest the following cycle (MDU min latency: 2 cycles to we).
//  - FIFO order strict; head/tail pointers wrap modulo DEPTH.
//  - q_busy checks valid queue entries only; entry being popped counts as busy that cycle.
//    The register file forwards WD on A==A3, so the output register needs no check.
//  - No reordering across sources; WAW vs. a queued MDU result is prevented by the
//    hazard unit stalling on q_busy before the pipeline writes the same register.
// CONFIGURATION
//  WB_STARVE_GUARD_EN defined: age counter counts cycles the head is present and not
//    popped; at age==STARVE_LIMIT-1, p_stall=1 for one cycle, p_valid is ignored that
//    cycle, head pops; counter clears on every pop or when count==0.
//  Not defined: no counter; p_stall tied 0; pipeline may starve the queue indefinitely.
// STRUCTURE
//  Shared package wb_pkg: REG_AW=5, DATA_W=32, REG_ZERO=5'd0,
//    typedef struct {addr[4:0], data[31:0], pc[31:0]} wb_req_t.
//  One sub-module: wb_fifo (DEPTH entries of wb_req_t, push/pop, count, per-entry
//    valid+addr exposed for the busy compare). Arbiter, issue register, guard at top.
// TESTING
//  1 p_valid=1,p_addr=8,p_data=0x1234,p_pc=0x3000 -> next edge we=1,wa=8,wd=0x1234,wpc=0x3000.
//  2 idle pipeline, m push addr=9,data=0xCAFE -> count=1, q_busy(9)=1, we=1,wa=9 two edges after push.
//  3 p_valid held, 5 m pushes -> m_ready=0 after 4th (count=4); p drops -> 4 writes in order.
//  4 p_addr=0 and m_addr=0 pushes -> we stays 0, m handshake completes, count stays 0.
//  5 3 entries queued, rst_n pulsed low mid-cycle -> we=0,count=0,q_busy=0,m_ready=0 at once.
//  6 guard build, 1 entry, p_valid held 10 cycles -> p_stall=1 on 8th cycle, entry issued;
//    non-guard build -> entry waits until p_valid drops.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back widths and the queued write request type
package wb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: MDU result queue with per-entry valid/addr exposed for hazard compares
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  wb_req_t                            din,
  output wb_req_t                            head,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   vld,
  output logic [DEPTH-1:0][REG_AW-1:0]       addrs
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_req_t mem [DEPTH];
  logic [AW-1:0] hd, tl;
  always_ff @(posedge clk) begin
    if (push) mem[tl] <= din;
  end
  // push never targets the head slot while it is popped: push needs !full, pop needs !empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        vld[tl] <= 1'b1;
        tl      <= tl + 1'b1;
      end
      if (pop) begin
        vld[hd] <= 1'b0;
        hd      <= hd + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[hd];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) addrs[i] = mem[i].addr;
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges pipeline and MDU write-backs onto one register-file write port
// Optional starvation guard for the MDU queue: define WB_STARVE_GUARD_EN.
module grf_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_valid,
  input  logic [4:0]              p_addr,
  input  logic [31:0]             p_data,
  input  logic [31:0]             p_pc,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [4:0]              m_addr,
  input  logic [31:0]             m_data,
  input  logic [31:0]             m_pc,
  output logic                    we,
  output logic [4:0]              wa,
  output logic [31:0]             wd,
  output logic [31:0]             wpc,
  input  logic [4:0]              q_addr1,
  input  logic [4:0]              q_addr2,
  output logic                    q_busy1,
  output logic                    q_busy2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    p_stall
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  wb_req_t head;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0][REG_AW-1:0] addrs;
  logic push, pop, p_win, b1, b2;
  assign m_ready = rst_n && (count < FULL);
  assign push    = m_valid && m_ready && m_addr != REG_ZERO;
  assign p_win   = p_valid && p_addr != REG_ZERO && !p_stall;
  assign pop     = !p_win && count != '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({m_addr, m_data, m_pc}),
    .head  (head),
    .count (count),
    .vld   (vld),
    .addrs (addrs)
  );
`ifdef WB_STARVE_GUARD_EN
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  logic [AGW-1:0] age;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= '0;
    else        age <= (pop || count == '0) ? '0 : age + 1'b1;
  end
  assign p_stall = count != '0 && age == AGW'(STARVE_LIMIT - 1);
`else
  assign p_stall = 1'b0;
`endif
  always_comb begin
    b1 = 1'b0;
    b2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b1 = b1 | (vld[i] && addrs[i] == q_addr1);
      b2 = b2 | (vld[i] && addrs[i] == q_addr2);
    end
  end
  assign q_busy1 = b1 && q_addr1 != REG_ZERO;
  assign q_busy2 = b2 && q_addr2 != REG_ZERO;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we  <= 1'b0;
      wa  <= '0;
      wd  <= '0;
      wpc <= '0;
    end else begin
      we <= p_win || pop;
      if (p_win)    {wa, wd, wpc} <= {p_addr, p_data, p_pc};
      else if (pop) {wa, wd, wpc} <= head;
    end
  end
endmodule
